// File: rtl/ip4_rtl_pkg.sv
// Shared sizing, queue entry type and pointer helper for the RFM write-back collector.
package ip4_rtl_pkg;
    localparam int NUM_FU        = 3;
    localparam int NUM_SP        = 8;
    localparam int NUM_BK        = 4;
    localparam int WORD_BITS     = 32;
    localparam int ADR_BITS      = 6;
    localparam int RFM_WBQ_DEPTH = 4;
    localparam int BK_BITS       = $clog2(NUM_BK);
    localparam int PTR_BITS      = $clog2(RFM_WBQ_DEPTH);
    localparam int CNT_BITS      = $clog2(RFM_WBQ_DEPTH + 1);

    typedef struct packed {
        logic [ADR_BITS-1:0]                  adr;
        logic [NUM_SP-1:0]                    msk;
        logic [NUM_SP-1:0][WORD_BITS-1:0]     dat;
    } rfm_wb_req_s;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_BITS-1:0] ptr_add(input logic [PTR_BITS-1:0] ptr,
                                                   input logic [CNT_BITS-1:0] n);
        int sum;
        sum = int'(ptr) + int'(n);
        return PTR_BITS'(sum % RFM_WBQ_DEPTH);
    endfunction
endpackage

// File: rtl/ip4_rtl_rfm_wbq.sv
// Single-bank write-back queue: NUM_FU ordered push ports, one pop per cycle.
module ip4_rtl_rfm_wbq
    import ip4_rtl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_FU-1:0]        push_en,
    input  rfm_wb_req_s [NUM_FU-1:0] push_req,
    output logic [NUM_FU-1:0]        drop,
    output logic                     we,
    output rfm_wb_req_s              head,
    output logic                     busy,
    output logic                     thresh
);
    rfm_wb_req_s mem_reg [RFM_WBQ_DEPTH];

    logic [PTR_BITS-1:0]              wr_ptr_reg, wr_ptr_next;
    logic [PTR_BITS-1:0]              rd_ptr_reg, rd_ptr_next;
    logic [CNT_BITS-1:0]              count_reg, count_next;
    logic [CNT_BITS-1:0]              space, accepted;
    logic [NUM_FU-1:0]                wr_en;
    logic [NUM_FU-1:0][PTR_BITS-1:0]  wr_idx;
    logic                             pop;

    // The head always pops when present, so its slot counts as free for this cycle's pushes.
    always_comb begin
        pop      = (count_reg != '0);
        space    = CNT_BITS'(RFM_WBQ_DEPTH) - count_reg + CNT_BITS'(pop);
        accepted = '0;
        wr_en    = '0;
        wr_idx   = '0;
        drop     = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (push_en[f]) begin
                if (accepted < space) begin
                    wr_en[f]  = 1'b1;
                    wr_idx[f] = ptr_add(wr_ptr_reg, accepted);
                    accepted  = accepted + CNT_BITS'(1);
                end else begin
                    drop[f] = 1'b1;
                end
            end
        end
        count_next  = count_reg + accepted - CNT_BITS'(pop);
        wr_ptr_next = ptr_add(wr_ptr_reg, accepted);
        rd_ptr_next = ptr_add(rd_ptr_reg, CNT_BITS'(pop));
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < NUM_FU; f++) begin
            if (wr_en[f]) begin
                mem_reg[wr_idx[f]] <= push_req[f];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    assign we     = pop;
    assign busy   = pop;
    assign head   = pop ? mem_reg[rd_ptr_reg] : '0;
    assign thresh = (count_reg > CNT_BITS'(RFM_WBQ_DEPTH - NUM_FU));
endmodule

// File: rtl/ip4_rtl_rfm_wb.sv
// RFM write-back collector: routes FU results into per-bank queues and drains one write per bank per cycle.
module ip4_rtl_rfm_wb
    import ip4_rtl_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_FU-1:0]                       fu_en,
    input  logic [NUM_FU-1:0][BK_BITS-1:0]          fu_bk,
    input  logic [NUM_FU-1:0][ADR_BITS-1:0]         fu_adr,
    input  logic [NUM_FU-1:0][NUM_SP-1:0]           fu_msk,
    input  logic [NUM_FU-1:0][NUM_SP-1:0][WORD_BITS-1:0] fu_dat,
    output logic                                    stall,
    output logic [NUM_BK-1:0]                       bk_we,
    output logic [NUM_BK-1:0][ADR_BITS-1:0]         bk_adr,
    output logic [NUM_BK-1:0][NUM_SP-1:0]           bk_msk,
    output logic [NUM_BK-1:0][NUM_SP-1:0][WORD_BITS-1:0] bk_dat,
    output logic [NUM_BK-1:0]                       bk_busy,
    output logic                                    ovf
);
    rfm_wb_req_s [NUM_BK-1:0] head;
    logic [NUM_BK-1:0]        thresh;
    logic [NUM_BK-1:0]        drop_any;
    logic                     ovf_reg;

    for (genvar gi = 0; gi < NUM_BK; gi++) begin : g_bank
        logic [NUM_FU-1:0]        push_en;
        rfm_wb_req_s [NUM_FU-1:0] push_req;
        logic [NUM_FU-1:0]        drop;

        // All-zero masks would only burn a write slot, so they never enter a queue.
        for (genvar fi = 0; fi < NUM_FU; fi++) begin : g_fu
            assign push_en[fi]      = fu_en[fi] && (fu_msk[fi] != '0) && (fu_bk[fi] == BK_BITS'(gi));
            assign push_req[fi].adr = fu_adr[fi];
            assign push_req[fi].msk = fu_msk[fi];
            assign push_req[fi].dat = fu_dat[fi];
        end

        ip4_rtl_rfm_wbq u_wbq (
            .clk      (clk),
            .rst      (rst),
            .push_en  (push_en),
            .push_req (push_req),
            .drop     (drop),
            .we       (bk_we[gi]),
            .head     (head[gi]),
            .busy     (bk_busy[gi]),
            .thresh   (thresh[gi])
        );

        assign drop_any[gi] = |drop;
        assign bk_adr[gi]   = head[gi].adr;
        assign bk_msk[gi]   = head[gi].msk;
        assign bk_dat[gi]   = head[gi].dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (|drop_any) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf   = ovf_reg;
    assign stall = |thresh;
endmodule

// File: tb/tb_ip4_rtl_rfm_wb.sv
// Directed bench for ip4_rtl_rfm_wb with a queue-level reference model checked every cycle.
module tb_ip4_rtl_rfm_wb;
    import ip4_rtl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic [NUM_FU-1:0]                            fu_en;
    logic [NUM_FU-1:0][BK_BITS-1:0]               fu_bk;
    logic [NUM_FU-1:0][ADR_BITS-1:0]              fu_adr;
    logic [NUM_FU-1:0][NUM_SP-1:0]                fu_msk;
    logic [NUM_FU-1:0][NUM_SP-1:0][WORD_BITS-1:0] fu_dat;
    logic                                         stall;
    logic [NUM_BK-1:0]                            bk_we;
    logic [NUM_BK-1:0][ADR_BITS-1:0]              bk_adr;
    logic [NUM_BK-1:0][NUM_SP-1:0]                bk_msk;
    logic [NUM_BK-1:0][NUM_SP-1:0][WORD_BITS-1:0] bk_dat;
    logic [NUM_BK-1:0]                            bk_busy;
    logic                                         ovf;

    always #5 clk = ~clk;

    ip4_rtl_rfm_wb dut (
        .clk(clk), .rst(rst),
        .fu_en(fu_en), .fu_bk(fu_bk), .fu_adr(fu_adr), .fu_msk(fu_msk), .fu_dat(fu_dat),
        .stall(stall), .bk_we(bk_we), .bk_adr(bk_adr), .bk_msk(bk_msk), .bk_dat(bk_dat),
        .bk_busy(bk_busy), .ovf(ovf)
    );

    typedef struct {
        logic [ADR_BITS-1:0]              adr;
        logic [NUM_SP-1:0]                msk;
        logic [NUM_SP-1:0][WORD_BITS-1:0] dat;
    } ment_t;

    ment_t mq [NUM_BK][$];
    bit    m_ovf;
    bit    cmp_on = 1'b0;
    int    n_cmp  = 0;
    int    n_bad  = 0;
    logic [NUM_SP-1:0][WORD_BITS-1:0] img [NUM_BK][64];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: each bank is an ordered list of entries, head written and removed every cycle.
    always @(posedge clk or posedge rst) begin : model
        ment_t e;
        int    b;
        if (rst) begin
            for (int k = 0; k < NUM_BK; k++) mq[k].delete();
            m_ovf = 1'b0;
        end else begin
            for (int k = 0; k < NUM_BK; k++)
                if (mq[k].size() != 0) void'(mq[k].pop_front());
            for (int f = 0; f < NUM_FU; f++) begin
                if (fu_en[f] && fu_msk[f] != '0) begin
                    b     = int'(fu_bk[f]);
                    e.adr = fu_adr[f];
                    e.msk = fu_msk[f];
                    e.dat = fu_dat[f];
                    if (mq[b].size() < RFM_WBQ_DEPTH) mq[b].push_back(e);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    // Bank array image built from the writes the DUT issues.
    always @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NUM_BK; b++)
                if (bk_we[b])
                    for (int l = 0; l < NUM_SP; l++)
                        if (bk_msk[b][l]) img[b][bk_adr[b]][l] = bk_dat[b][l];
        end
    end

    always @(negedge clk) begin : cmp
        logic [NUM_BK-1:0] ewe;
        bit                est;
        if (cmp_on) begin
            ewe = '0;
            est = 1'b0;
            for (int b = 0; b < NUM_BK; b++) begin
                ewe[b] = (mq[b].size() != 0);
                if (mq[b].size() > RFM_WBQ_DEPTH - NUM_FU) est = 1'b1;
                if (ewe[b]) begin
                    check($sformatf("b%0d_adr", b), bk_adr[b], mq[b][0].adr);
                    check($sformatf("b%0d_msk", b), bk_msk[b], mq[b][0].msk);
                    check($sformatf("b%0d_dat", b), bk_dat[b], mq[b][0].dat);
                end else begin
                    check($sformatf("b%0d_idle", b), {bk_adr[b], bk_msk[b], bk_dat[b]}, '0);
                end
            end
            check("bk_we", bk_we, ewe);
            check("bk_busy", bk_busy, ewe);
            check("stall", stall, est);
            check("ovf", ovf, m_ovf);
        end
    end

    task automatic idle();
        fu_en = '0; fu_bk = '0; fu_adr = '0; fu_msk = '0; fu_dat = '0;
    endtask

    task automatic setfu(input int f, input int bk, input int adr, input logic [7:0] msk, input int base);
        fu_en[f]  = 1'b1;
        fu_bk[f]  = BK_BITS'(bk);
        fu_adr[f] = ADR_BITS'(adr);
        fu_msk[f] = msk;
        for (int l = 0; l < NUM_SP; l++) fu_dat[f][l] = WORD_BITS'(base + l);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [NUM_SP-1:0][WORD_BITS-1:0] er;
        for (int b = 0; b < NUM_BK; b++)
            for (int r = 0; r < 64; r++) img[b][r] = '0;
        rst = 1'b1;
        idle();
        cmp_on = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", bk_we, 4'b0000);
        check("rst_busy", bk_busy, 4'b0000);
        check("rst_stall", stall, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        @(negedge clk); #1 rst = 1'b0;
        cyc();

        // single write, bank 2 row 5
        setfu(0, 2, 5, 8'hFF, 0);
        cyc(); idle();
        check("t1_we", bk_we, 4'b0100);
        check("t1_adr", bk_adr[2], 6'd5);
        check("t1_lane7", bk_dat[2][7], 32'd7);
        check("t1_busy", bk_busy, 4'b0100);
        cyc();
        check("t1_busy_drop", bk_busy, 4'b0000);

        // three FUs into bank 1
        setfu(0, 1, 1, 8'hFF, 100);
        setfu(1, 1, 2, 8'hFF, 200);
        setfu(2, 1, 3, 8'hFF, 300);
        cyc(); idle();
        check("t2_adr0", bk_adr[1], 6'd1);
        check("t2_stall0", stall, 1'b1);
        cyc();
        check("t2_adr1", bk_adr[1], 6'd2);
        check("t2_stall1", stall, 1'b1);
        cyc();
        check("t2_adr2", bk_adr[1], 6'd3);
        check("t2_stall2", stall, 1'b0);
        cyc();
        check("t2_done", bk_we, 4'b0000);

        // same bank, same row: fu2 lanes 0-3 override fu0
        setfu(0, 0, 7, 8'hFF, 'hA0);
        setfu(2, 0, 7, 8'h0F, 'hB0);
        cyc(); idle();
        cyc(); cyc();
        for (int l = 0; l < NUM_SP; l++) er[l] = (l < 4) ? WORD_BITS'('hB0 + l) : WORD_BITS'('hA0 + l);
        check("t3_row", img[0][7], er);

        // zero mask is discarded
        setfu(0, 0, 9, 8'h00, 55);
        cyc(); idle();
        check("t4_we", bk_we, 4'b0000);
        check("t4_busy", bk_busy, 4'b0000);

        // overflow on bank 3
        for (int c = 0; c < 3; c++) begin
            for (int f = 0; f < NUM_FU; f++) setfu(f, 3, 10 + 3 * c + f, 8'hFF, 1000 * (c + 1) + 16 * f);
            cyc();
            if (c == 0) begin
                check("t5_adr_c0", bk_adr[3], 6'd10);
                check("t5_ovf_c0", ovf, 1'b0);
            end else if (c == 1) begin
                check("t5_adr_c1", bk_adr[3], 6'd11);
                check("t5_ovf_c1", ovf, 1'b1);
            end
        end
        idle();
        check("t5_adr_c2", bk_adr[3], 6'd12);
        cyc(); check("t5_adr_d0", bk_adr[3], 6'd13);
        cyc(); check("t5_adr_d1", bk_adr[3], 6'd14);
        cyc(); check("t5_adr_d2", bk_adr[3], 6'd16);
        cyc(); check("t5_empty", bk_we, 4'b0000);
        check("t5_ovf_sticky", ovf, 1'b1);

        // reset mid-drain
        setfu(0, 2, 20, 8'hFF, 0);
        setfu(1, 2, 21, 8'hFF, 0);
        setfu(2, 2, 22, 8'hFF, 0);
        cyc(); idle();
        check("t6_pre", bk_adr[2], 6'd20);
        #1 rst = 1'b1;
        #1;
        check("t6_we", bk_we, 4'b0000);
        check("t6_busy", bk_busy, 4'b0000);
        check("t6_stall", stall, 1'b0);
        check("t6_ovf", ovf, 1'b0);
        @(negedge clk); #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t6_no_stale", {bk_we, bk_busy}, 8'h00);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ip4_rtl_rfm_wb.md
# ip4_rtl_rfm_wb

Register-file write-back collector at the receiving end of the SPA-to-RFM result path. Accepts up to NUM_FU per-cycle result writes from the stream processor array, sorts them into per-bank queues, and drains each queue through that bank's single write port. Asserts stall toward issue when bank conflicts could overflow a queue. Sits inside the RFM, between the SPA result registers and the register bank arrays.

## Interface
- NUM_FU, 3, functional units issuing writes per cycle
- NUM_SP, 8, lanes per write
- NUM_BK, 4, register banks (one write port each)
- WORD_BITS, 32, lane data width
- ADR_BITS, 6, bank-local row address width
- QDEPTH, 4, entries per bank queue (must be >= NUM_FU + 1)
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- fu_en  in  [NUM_FU]  write request valid per FU
- fu_bk  in  [NUM_FU][$clog2(NUM_BK)]  target bank
- fu_adr  in  [NUM_FU][ADR_BITS]  target row
- fu_msk  in  [NUM_FU][NUM_SP]  lane write enables
- fu_dat  in  [NUM_FU][NUM_SP][WORD_BITS]  lane data
- stall  out  1  upstream must present no fu_en while high
- bk_we  out  [NUM_BK]  bank write strobe
- bk_adr  out  [NUM_BK][ADR_BITS]  bank write row
- bk_msk  out  [NUM_BK][NUM_SP]  bank lane enables
- bk_dat  out  [NUM_BK][NUM_SP][WORD_BITS]  bank write data
- bk_busy  out  [NUM_BK]  bank queue non-empty (for RFM read-hazard checks)
- ovf  out  1  sticky: a request was dropped on a full queue

## Operation
- Request from FU f is valid when fu_en[f] and fu_msk[f] != 0; all-zero mask is discarded, no queue entry.
- Enqueue: on each rising edge, valid requests push into queue fu_bk[f] in ascending FU order (fu0 first); several FUs may hit the same bank in one cycle.
- Dequeue: each non-empty queue drives its head on bk_we/bk_adr/bk_msk/bk_dat and pops it at the same edge; one pop per bank per cycle.
- Push and pop in the same cycle on the same bank both occur; count_next = count + pushes - pop.
- Same bank, same row in one cycle: later FU writes later, so the higher FU index wins per lane; lanes not masked by it keep the earlier value.
- Full: a push exceeding QDEPTH after this cycle's pop is dropped, ovf set; ovf clears only on rst. Other pushes in the same cycle still proceed.
- stall = 1 when any bank count > QDEPTH - NUM_FU (derived from registered counts).
- Outputs with empty queue: bk_we = 0, bk_adr/bk_msk/bk_dat = 0.
- bk_busy[b] = count[b] != 0.

## Timing
- Latency: request sampled at edge N appears on bk_we at cycle N+1 (after edge N); no combinational input-to-output path.
- stall is combinational from registered state only; it rises in the cycle after the push that crosses the threshold.
- A bank receiving k pushes drains in k cycles at 1 write/cycle, in FIFO order.
- Reset (any time, including mid-drain): all queues emptied, pointers/counts to 0, bk_we = 0, bk_adr/bk_msk/bk_dat = 0, bk_busy = 0, stall = 0, ovf = 0. In-flight entries are lost.
- Pointers wrap modulo QDEPTH; count has $clog2(QDEPTH+1) bits.

## Structure
- ip4_rtl_pkg: typedef rfm_wb_req_s {adr, msk, dat}; constants NUM_BK, RFM_WBQ_DEPTH.
- Sub-module ip4_rtl_rfm_wbq: single-bank queue with NUM_FU push ports (priority-ordered), one pop port, count and full/threshold outputs; instantiated NUM_BK times. Top level does bank decode, stall OR-reduction, ovf latch.

## Test plan
- Single write fu0 bank 2 row 5 msk 8'hFF dat lane i = i: next cycle bk_we = 4'b0100, bk_adr[2] = 5, data matches; bk_busy[2] drops the cycle after.
- fu0/fu1/fu2 all to bank 1, rows 1/2/3: bank 1 writes rows 1,2,3 on three consecutive cycles; stall high from the cycle after the push until count <= 1.
- fu0 and fu2 same bank, same row 7, fu0 msk 8'hFF dat A, fu2 msk 8'h0F dat B: final row lanes 0-3 = B, lanes 4-7 = A (two writes, fu0 first).
- fu_en with msk 0 to bank 0: no bk_we, bk_busy stays 0.
- Ignore stall, push 3 per cycle to bank 3 for 3 cycles: ovf sets on the first dropped push and stays 1; surviving entries drain in order.
- Assert rst with 3 entries queued: bk_we, bk_busy, stall, ovf all 0 immediately; after release, no stale writes.
